// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the uart_tx arbiter (state encoding, id width, timeout default).
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } arb_state_t;

  localparam int TIMEOUT_CYC_DEF = 65535;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request searching upward from last_grant+1, wrapping.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]        req,
  input  logic [id_w(N_REQ)-1:0]  last_grant,
  output logic [N_REQ-1:0]        grant,
  output logic [id_w(N_REQ)-1:0]  id,
  output logic                    any
);

  localparam int ID_W = id_w(N_REQ);

  int w_idx;

  // NOTE: every output gets a default before the search loop so no path leaves a
  // signal unassigned; a missing default here would infer a latch.
  always_comb begin
    grant = '0;
    id    = '0;
    any   = 1'b0;
    w_idx = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = (int'(last_grant) + k) % N_REQ;
      if (!any && req[w_idx]) begin
        any          = 1'b1;
        id           = ID_W'(w_idx);
        grant[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, frame-locking arbiter sharing one uart_tx among N_REQ byte streams.
// Optional watchdog on WAIT/HOLD enabled by `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_finish,
  output logic                      busy,
  output logic [id_w(N_REQ)-1:0]    grant_id,
  output logic                      timeout_err
);

  localparam int ID_W = id_w(N_REQ);

  arb_state_t        r_state, w_state_nxt;
  logic [ID_W-1:0]   r_last_grant, r_grant_id, w_sel_id;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_last_q;
  logic              w_accept, w_release, w_tmo_hit, w_tmo_fire;
  logic [N_REQ-1:0]  w_pick_grant;
  logic [ID_W-1:0]   w_pick_id;
  logic              w_pick_any;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req        (req_valid),
    .last_grant (r_last_grant),
    .grant      (w_pick_grant),
    .id         (w_pick_id),
    .any        (w_pick_any)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_sel_id    = r_grant_id;
    w_accept    = 1'b0;
    w_release   = 1'b0;
    w_tmo_fire  = 1'b0;
    case (r_state)
      IDLE: begin
        w_sel_id = w_pick_id;
        w_accept = w_pick_any;
        if (w_accept) w_state_nxt = START;
      end
      START: w_state_nxt = WAIT;
      WAIT: begin
        // A finish coincident with the watchdog expiry wins; no error is raised.
        if (tx_finish) begin
          w_state_nxt = r_last_q ? IDLE : HOLD;
          w_release   = r_last_q;
        end else if (w_tmo_hit) begin
          w_state_nxt = IDLE;
          w_release   = 1'b1;
          w_tmo_fire  = 1'b1;
        end
      end
      HOLD: begin
        w_accept = req_valid[r_grant_id];
        if (w_accept) begin
          w_state_nxt = START;
        end else if (w_tmo_hit) begin
          w_state_nxt = IDLE;
          w_release   = 1'b1;
          w_tmo_fire  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Combinational outputs are masked during reset so a reset mid-START never leaks a pulse.
  assign req_ready   = (w_accept && !rst_in) ? (N_REQ'(1) << w_sel_id) : '0;
  assign tx_start    = (r_state == START) && !rst_in;
  assign busy        = (r_state != IDLE) && !rst_in;
  assign timeout_err = w_tmo_fire && !rst_in;
  assign tx_data     = r_tx_data;
  assign grant_id    = r_grant_id;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state      <= IDLE;
      r_last_grant <= ID_W'(N_REQ - 1);
      r_grant_id   <= '0;
      r_tx_data    <= '0;
      r_last_q     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_tx_data  <= req_data[w_sel_id*DATA_W +: DATA_W];
        r_last_q   <= req_last[w_sel_id];
        r_grant_id <= w_sel_id;
      end
      if (w_release) r_last_grant <= r_grant_id;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_tmo_cnt;

  // Counter restarts on every state entry and only advances while parked in WAIT or HOLD.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_tmo_cnt <= '0;
    end else if ((w_state_nxt != r_state) || !((r_state == WAIT) || (r_state == HOLD))) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign w_tmo_hit = (r_tmo_cnt == CNT_W'(TIMEOUT_CYC));
`else
  assign w_tmo_hit = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (4 requesters, 8-bit bytes, TIMEOUT_CYC=20).
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk_in = 1'b0;
  logic            rst_in;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            tx_start;
  logic [DW-1:0]   tx_data;
  logic            tx_finish;
  logic            busy;
  logic [1:0]      grant_id;
  logic            timeout_err;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  always #5 clk_in = ~clk_in;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .TIMEOUT_CYC(20)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_finish   (tx_finish),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
    req_valid[i]         = v;
    req_data[i*DW +: DW] = d;
    req_last[i]          = l;
  endtask

  // Serve one byte from requester id: ack, start pulse, finish 10 cycles after start.
  task automatic serve(input int id, input logic [7:0] d, input logic last);
    int guard;
    guard = 0;
    #1;
    while (req_ready == '0 && guard < 20) begin
      tick();
      #1;
      guard++;
    end
    check($sformatf("ready_req%0d", id), 32'(req_ready), 32'(1) << id);
    tick();
    check("start_pulse", 32'(tx_start), 32'd1);
    check("start_grant", 32'(grant_id), 32'(id));
    check("start_data", 32'(tx_data), 32'(d));
    repeat (10) tick();
    check("wait_quiet", {30'd0, tx_start, |req_ready}, 32'd0);
    tx_finish = 1'b1;
    tick();
    tx_finish = 1'b0;
    check("busy_after_finish", 32'(busy), 32'(!last));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen;
    rst_in    = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_finish = 1'b0;
    tick();
    tick();
    check("rst_busy_in_reset", 32'(busy), 32'd0);
    rst_in = 1'b0;
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(tx_start), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_tmo", 32'(timeout_err), 32'd0);

    // Single byte from requester 2.
    set_req(2, 1'b1, 8'h5A, 1'b1);
    #1;
    check("t1_ready_same_cycle", 32'(req_ready), 32'b0100);
    check("t1_no_start_yet", 32'(tx_start), 32'd0);
    tick();
    set_req(2, 1'b0, 8'h5A, 1'b1);
    check("t1_start", 32'(tx_start), 32'd1);
    check("t1_data", 32'(tx_data), 32'h5A);
    check("t1_grant", 32'(grant_id), 32'd2);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_ready_start", 32'(req_ready), 32'd0);
    tick();
    check("t1_start_one_cycle", 32'(tx_start), 32'd0);
    tx_finish = 1'b1;
    tick();
    tx_finish = 1'b0;
    check("t1_idle_after_finish", 32'(busy), 32'd0);

    // Fairness from a fresh pointer: 0,1,2,3,0.
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'hA0 + 8'(i), 1'b1);
    for (int k = 0; k < 5; k++) serve(k % N, 8'hA0 + 8'(k % N), 1'b1);
    req_valid = '0;

    // Frame lock: req1 two-byte frame while req0/req3 wait; then order 3, 0.
    set_req(0, 1'b1, 8'hA0, 1'b1);
    set_req(3, 1'b1, 8'hA3, 1'b1);
    set_req(1, 1'b1, 8'h11, 1'b0);
    serve(1, 8'h11, 1'b0);
    set_req(1, 1'b0, 8'h22, 1'b1);
    repeat (3) begin
      #1;
      check("lock_gap_ready", 32'(req_ready), 32'd0);
      check("lock_gap_busy", 32'(busy), 32'd1);
      tick();
    end
    set_req(1, 1'b1, 8'h22, 1'b1);
    serve(1, 8'h22, 1'b1);
    set_req(1, 1'b0, 8'h22, 1'b1);
    serve(3, 8'hA3, 1'b1);
    set_req(3, 1'b0, 8'hA3, 1'b1);
    serve(0, 8'hA0, 1'b1);
    req_valid = '0;

    // Finish pulses during START and HOLD must be ignored.
    set_req(1, 1'b1, 8'h33, 1'b0);
    #1;
    check("ign_ready", 32'(req_ready), 32'b0010);
    tick();
    set_req(1, 1'b1, 8'h44, 1'b1);
    tx_finish = 1'b1;
    check("ign_start", 32'(tx_start), 32'd1);
    check("ign_start_data", 32'(tx_data), 32'h33);
    tick();
    tx_finish = 1'b0;
    check("ign_start_finish_ready", 32'(req_ready), 32'd0);
    check("ign_start_finish_busy", 32'(busy), 32'd1);
    tick();
    check("ign_still_wait", 32'(tx_start), 32'd0);
    tx_finish = 1'b1;
    set_req(1, 1'b0, 8'h44, 1'b1);
    tick();
    check("ign_hold_busy", 32'(busy), 32'd1);
    tick();
    tx_finish = 1'b0;
    check("ign_hold_finish_busy", 32'(busy), 32'd1);
    check("ign_hold_no_start", 32'(tx_start), 32'd0);
    set_req(1, 1'b1, 8'h44, 1'b1);
    #1;
    check("ign_hold_ready", 32'(req_ready), 32'b0010);
    tick();
    set_req(1, 1'b0, 8'h44, 1'b1);
    check("ign_second_data", 32'(tx_data), 32'h44);
    tick();
    tx_finish = 1'b1;
    tick();
    tx_finish = 1'b0;
    check("ign_done", 32'(busy), 32'd0);

    // Reset in WAIT while req2 owns the lock.
    set_req(2, 1'b1, 8'h55, 1'b0);
    #1;
    check("rmid_ready", 32'(req_ready), 32'b0100);
    tick();
    tick();
    rst_in = 1'b1;
    set_req(0, 1'b1, 8'h66, 1'b1);
    #1;
    check("rmid_busy_in_reset", 32'(busy), 32'd0);
    check("rmid_ready_in_reset", 32'(req_ready), 32'd0);
    tick();
    rst_in = 1'b0;
    check("rmid_data", 32'(tx_data), 32'd0);
    check("rmid_grant", 32'(grant_id), 32'd0);
    check("rmid_no_start", 32'(tx_start), 32'd0);
    #1;
    check("rmid_next_req0", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    check("rmid_req0_data", 32'(tx_data), 32'h66);
    tick();
    tx_finish = 1'b1;
    tick();
    tx_finish = 1'b0;

    // Never finish: watchdog behaviour depends on build.
    set_req(1, 1'b1, 8'h77, 1'b1);
    set_req(2, 1'b1, 8'h88, 1'b1);
    #1;
    check("tmo_ready", 32'(req_ready), 32'b0010);
    tick();
    tick();
    seen = 0;
`ifdef UART_ARB_TIMEOUT_EN
    for (int c = 0; c < 20; c++) begin
      if (timeout_err) seen++;
      tick();
    end
    check("tmo_early", 32'(seen), 32'd0);
    check("tmo_pulse", 32'(timeout_err), 32'd1);
    check("tmo_busy_at_pulse", 32'(busy), 32'd1);
    tick();
    check("tmo_pulse_end", 32'(timeout_err), 32'd0);
    check("tmo_idle", 32'(busy), 32'd0);
    #1;
    check("tmo_next_req2", 32'(req_ready), 32'b0100);
`else
    for (int c = 0; c < 200; c++) begin
      if (timeout_err || !busy) seen++;
      tick();
    end
    check("notmo_stuck", 32'(seen), 32'd0);
    check("notmo_busy", 32'(busy), 32'd1);
`endif
    req_valid = '0;
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    tick();
    check("end_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
